// File: rtl/nn_neuron_mac.sv
// rtl/nn_neuron_mac.sv - single-neuron MAC: pops N_INPUTS FIFO words, weights them, adds bias, ReLU + saturate
module nn_neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        relu_en,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [15:0]                 w_data,
  input  logic                        bias_we,
  input  logic [31:0]                 bias_data,
  input  logic [31:0]                 fifo_data_i,
  input  logic                        fifo_empty_i,
  output logic                        fifo_rd_o,
  output logic                        busy,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_data
);

  localparam int AW = $clog2(N_INPUTS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_ACT   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [AW-1:0]           idx;
  logic                    relu_q;
  logic signed [15:0]      weight [N_INPUTS];
  logic [31:0]             bias;

  logic [31:0]             bias_eff;
  logic signed [15:0]      operand;
  logic signed [31:0]      prod;
  logic                    acc_fits;
  logic [31:0]             result;
  logic                    unused_hi;

  assign unused_hi = ^fifo_data_i[31:16];

  // A bias write coinciding with start must be seen by that run.
  assign bias_eff = bias_we ? bias_data : bias;

  assign operand   = fifo_data_i[15:0];
  assign prod      = operand * weight[idx];
  assign fifo_rd_o = (state == S_ACCUM) && !fifo_empty_i;
  assign busy      = (state != S_IDLE);

  // Accumulator fits in 32 bits when all bits above bit 31 match the sign.
  assign acc_fits = (&acc[ACC_W-1:31]) || !(|acc[ACC_W-1:31]);

  always_comb begin
    result = acc[31:0];
    if (relu_q && acc[ACC_W-1]) begin
      result = 32'h0000_0000;
    end else if (!acc_fits) begin
      result = acc[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      relu_q    <= 1'b0;
      bias      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        weight[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (w_we) begin
            weight[w_addr] <= w_data;
          end
          if (bias_we) begin
            bias <= bias_data;
          end
          if (start) begin
            acc    <= {{(ACC_W-32){bias_eff[31]}}, bias_eff};
            idx    <= '0;
            relu_q <= relu_en;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!fifo_empty_i) begin
            acc <= acc + {{(ACC_W-32){prod[31]}}, prod};
            idx <= idx + AW'(1);
            if (idx == AW'(N_INPUTS - 1)) begin
              state <= S_ACT;
            end
          end
        end
        S_ACT: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        default: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// tb/tb_nn_neuron_mac.sv - directed-vector bench for nn_neuron_mac with a simple FIFO model
module tb_nn_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        relu_en = 1'b0;
  logic        w_we = 1'b0;
  logic [2:0]  w_addr = '0;
  logic [15:0] w_data = '0;
  logic        bias_we = 1'b0;
  logic [31:0] bias_data = '0;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_o;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  int          head = 0;
  int          tail = 0;
  logic        hold_empty = 1'b0;

  always #5 clk = ~clk;

  nn_neuron_mac #(.N_INPUTS(8), .ACC_W(40)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .relu_en     (relu_en),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .bias_we     (bias_we),
    .bias_data   (bias_data),
    .fifo_data_i (fifo_data),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_o   (fifo_rd_o),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  assign fifo_data  = mem[8'(head)];
  assign fifo_empty = (head == tail) || hold_empty;

  always @(posedge clk) begin
    if (fifo_rd_o) head <= head + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    mem[8'(tail)] = v;
    tail++;
  endtask

  task automatic push_seq(input logic [15:0] hi);
    for (int i = 1; i <= 8; i++) push({hi, 16'(i)});
  endtask

  task automatic push_const(input logic [15:0] v);
    for (int i = 0; i < 8; i++) push({16'h0000, v});
  endtask

  task automatic set_weights(input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_we = 1'b1; w_addr = 3'(i); w_data = w;
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic set_bias(input logic [31:0] b);
    @(negedge clk);
    bias_we = 1'b1; bias_data = b;
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  task automatic run_neuron(input logic relu, input logic bwe, input logic [31:0] bval,
                            input int stall_at, input int stall_len,
                            output int cyc, output int npop);
    int base;
    int rem;
    @(negedge clk);
    base = head;
    rem  = stall_len;
    start = 1'b1; relu_en = relu; bias_we = bwe; bias_data = bval;
    @(negedge clk);
    start = 1'b0; relu_en = 1'b0; bias_we = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stall_len > 0 && (head - base) == stall_at && rem > 0) begin
        hold_empty = 1'b1;
        rem--;
        #1 check("stall_no_pop", 32'(fifo_rd_o), 32'd0);
      end else begin
        hold_empty = 1'b0;
      end
    end
    hold_empty = 1'b0;
    npop = head - base;
    if (cyc >= 60) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  int cyc;
  int npop;
  int base;
  logic [31:0] held;

  initial begin
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd_o), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Weights 1, bias 0, inputs 1..8 with junk in the ignored upper half
    set_weights(16'h0001);
    push_seq(16'hABCD);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("sum_latency", 32'(cyc), 32'd9);
    check("sum_pops", 32'(npop), 32'd8);
    check("sum_data", out_data, 32'd36);

    // Weights -1, bias 10 written in the same cycle as start
    set_weights(16'hFFFF);
    push_seq(16'h0000);
    run_neuron(1'b0, 1'b1, 32'd10, 0, 0, cyc, npop);
    check("neg_data", out_data, 32'hFFFF_FFE6);
    push_seq(16'h0000);
    run_neuron(1'b1, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("relu_data", out_data, 32'd0);

    set_weights(16'h7FFF);
    set_bias(32'h7FFF_FFFF);
    push_const(16'h7FFF);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("sat_max", out_data, 32'h7FFF_FFFF);

    set_weights(16'h8000);
    set_bias(32'h8000_0000);
    push_const(16'h7FFF);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("sat_min", out_data, 32'h8000_0000);

    // Three-cycle empty stall after the 4th pop
    set_weights(16'h0001);
    set_bias(32'd0);
    push_seq(16'h0000);
    run_neuron(1'b0, 1'b0, 32'd0, 4, 3, cyc, npop);
    check("stall_latency", 32'(cyc), 32'd12);
    check("stall_data", out_data, 32'd36);

    // Backpressure: result held, start and weight write ignored
    out_ready = 1'b0;
    push_seq(16'h0000);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    held = out_data;
    check("bp_first_data", held, 32'd36);
    for (int k = 0; k < 5; k++) begin
      start = (k == 1); w_we = (k == 1); w_addr = 3'd0; w_data = 16'h0005;
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, held);
      check("bp_busy", 32'(busy), 32'd1);
    end
    w_we = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_valid", 32'(out_valid), 32'd0);
    check("accept_start_ignored", 32'(busy), 32'd0);
    push_seq(16'h0000);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("weight_unchanged", out_data, 32'd36);

    // Async reset in the middle of accumulation
    set_weights(16'h0003);
    set_bias(32'd7);
    push_seq(16'h0000);
    @(negedge clk);
    base = head;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && (head - base) < 5; k++) @(negedge clk);
    check("mid_pops", 32'(head - base), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_rd", 32'(fifo_rd_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_seq(16'h0000);
    run_neuron(1'b0, 1'b0, 32'd0, 0, 0, cyc, npop);
    check("post_rst_latency", 32'(cyc), 32'd9);
    check("post_rst_data", out_data, 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_neuron_mac.md
Name: nn_neuron_mac

Overview:
Downstream consumer of the 8-entry input FIFO in the wishbone_nn datapath. Computes one neuron per start command: pops N_INPUTS words from the FIFO, multiplies each by a locally stored signed weight, and accumulates onto a bias. It then applies optional ReLU and 32-bit saturation, and presents the result on a valid/ready output to the wishbone read-back / next-layer logic.

Parameters:
N_INPUTS, 8, operands popped per neuron (2..16)
ACC_W, 40, accumulator width in bits (must be ≥ 32 + clog2(N_INPUTS) + 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle command to begin a neuron; honoured only in IDLE
relu_en  input  1  sampled with start; 1 = clamp negative results to 0
w_we  input  1  weight write strobe; honoured only in IDLE
w_addr  input  clog2(N_INPUTS)  weight index
w_data  input  16  signed weight
bias_we  input  1  bias write strobe; honoured only in IDLE
bias_data  input  32  signed bias
fifo_data_i  input  32  FIFO head word; low 16 bits = signed operand, upper bits ignored
fifo_empty_i  input  1  FIFO has no data
fifo_rd_o  output  1  pop strobe; combinational, head consumed at this edge
busy  output  1  high in any state other than IDLE
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  32  signed saturated result

Behaviour:
- Reset (async, any state): state = IDLE; acc, idx, out_data, relu latch = 0; out_valid = 0; all weights and bias = 0; fifo_rd_o = 0.
- States: IDLE, ACCUM, ACT, OUT.
- IDLE:
  - w_we writes weight[w_addr].
  - bias_we writes bias.
  - A write and start in the same cycle: the write lands, and the run uses the new value.
  - On start: acc ← sign-extended bias, idx ← 0, latch relu_en, go to ACCUM.
- ACCUM:
  - fifo_rd_o = !fifo_empty_i.
  - On a pop: acc ← acc + sext(fifo_data_i[15:0]) × weight[idx] (full 32-bit signed product, sign-extended to ACC_W); idx ← idx + 1.
  - Pop with idx == N_INPUTS-1 → ACT.
  - fifo_empty_i high → stall, with no pop and no state change.
- ACT: one cycle.
  - If relu latch set and acc < 0, the result is 0.
  - Otherwise saturate acc to the signed 32-bit range [0x80000000, 0x7FFFFFFF].
  - Register the result into out_data, set out_valid = 1, go to OUT.
- OUT:
  - out_data and out_valid are held stable.
  - On out_valid && out_ready: out_valid ← 0, go to IDLE.
  - A start arriving in the acceptance cycle is ignored.
- Ignored while busy: start, w_we and bias_we, with no side effect.
- fifo_rd_o is never asserted outside ACCUM.
- Latency with no stalls: start sampled at edge E0; pops at E1..E(N_INPUTS); out_valid rises at E(N_INPUTS+1). That is 9 cycles for N_INPUTS = 8. Each empty-FIFO stall cycle adds exactly one cycle.
- Accumulator arithmetic is wrap-free by the sizing of ACC_W; saturation happens only in ACT.
- Back-to-back neurons: the earliest next start is the cycle after the out handshake.

Test Plan:
- All weights 1, bias 0, relu_en 0, FIFO preloaded with 1..8, start → 8 consecutive fifo_rd_o pulses; out_valid rises 9 cycles after start; out_data = 36 (0x24).
- Weights −1, bias 10, inputs 1..8: relu_en 0 → out_data = −26 (0xFFFFFFE6); relu_en 1 → out_data = 0.
- Weights 0x7FFF, inputs 0x7FFF ×8, bias 0x7FFFFFFF → out_data = 0x7FFFFFFF. Weights 0x8000, inputs 0x7FFF, bias 0x80000000 → out_data = 0x80000000.
- fifo_empty_i forced high for 3 cycles after the 4th pop → fifo_rd_o low for those cycles; out_valid rises at cycle 12; result unchanged.
- out_ready held low 5 cycles → out_data and out_valid stable, busy stays 1; a start and a w_we pulse in that window are ignored (weight readback via the next run is unchanged).
- rst asserted after the 5th pop → immediately state IDLE, busy 0, out_valid 0, fifo_rd_o 0; a following run with no weight/bias writes yields out_data = 0.
